// File: rtl/pipe_run_controller_pkg.sv
// Shared constants for the pipeline run controller.
// State encoding, drain default and HALT opcode.
package pipe_run_controller_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_STEP   = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_HALTED = 3'd4;

   localparam int DRAIN_CYCLES_DEF = 3;

   localparam logic [5:0] HALT_OPCODE = 6'h3f;

   function automatic logic is_active(input logic [2:0] st);
      return (st == ST_RUN) || (st == ST_STEP);
   endfunction

endpackage

// File: rtl/pipe_run_controller_if.sv
// Control/status bundle between the run controller and the pipeline.
// master drives commands and hazard inputs, slave is the controller.
interface pipe_run_controller_if #(
   parameter int RBITS   = 5,
   parameter int CNTBITS = 32
);
   logic               i_start;
   logic               i_step;
   logic               i_halt_id;
   logic               i_flush_req;
   logic               i_idex_mem_read;
   logic [RBITS-1:0]   i_idex_rt;
   logic [RBITS-1:0]   i_ifid_rs;
   logic [RBITS-1:0]   i_ifid_rt;
   logic               o_pipe_en;
   logic               o_pc_write;
   logic               o_ifid_write;
   logic               o_ifid_flush;
   logic               o_idex_bubble;
   logic               o_halted;
   logic [CNTBITS-1:0] o_cycle_count;

   modport master (
      output i_start, i_step, i_halt_id, i_flush_req,
      output i_idex_mem_read, i_idex_rt, i_ifid_rs, i_ifid_rt,
      input  o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush,
      input  o_idex_bubble, o_halted, o_cycle_count
   );

   modport slave (
      input  i_start, i_step, i_halt_id, i_flush_req,
      input  i_idex_mem_read, i_idex_rt, i_ifid_rs, i_ifid_rt,
      output o_pipe_en, o_pc_write, o_ifid_write, o_ifid_flush,
      output o_idex_bubble, o_halted, o_cycle_count
   );
endinterface

// File: rtl/pipe_run_controller_hazard_detect.sv
// Load-use hazard detector: EX load feeding a source in ID.
// Register 0 never creates a dependency.
module hazard_detect #(
   parameter int RBITS = 5
) (
   input  logic             idex_mem_read,
   input  logic [RBITS-1:0] idex_rt,
   input  logic [RBITS-1:0] ifid_rs,
   input  logic [RBITS-1:0] ifid_rt,
   output logic             stall
);

   assign stall = idex_mem_read
                & (idex_rt != '0)
                & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

endmodule

// File: rtl/pipe_run_controller.sv
// Run/step/halt/drain controller with load-use stall and flush.
// PIPE_CYCLE_COUNT_EN adds the enabled-cycle counter.
module pipe_run_controller
   import pipe_run_controller_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int RBITS        = 5,
   parameter int CNTBITS      = 32
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   pipe_run_controller_if.slave bus
);

   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   logic [2:0]    state_q;
   logic [2:0]    state_d;
   logic [DW-1:0] drain_q;
   logic          drain_load;
   logic          stall;
   logic          active;
   logic          pipe_en;
   logic          pc_write;
   logic          ifid_write;
   logic          ifid_flush;
   logic          idex_bubble;
   logic          halted;

   hazard_detect #(.RBITS(RBITS)) u_hazard (
      .idex_mem_read (bus.i_idex_mem_read),
      .idex_rt       (bus.i_idex_rt),
      .ifid_rs       (bus.i_ifid_rs),
      .ifid_rt       (bus.i_ifid_rt),
      .stall         (stall)
   );

   assign active = is_active(state_q);

   // Next state and pipeline enables; halt beats stall beats flush.
   always_comb begin
      state_d     = state_q;
      drain_load  = 1'b0;
      pipe_en     = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (bus.i_start)
               state_d = ST_RUN;
            else if (bus.i_step)
               state_d = ST_STEP;
         end
         active: begin
            pipe_en = 1'b1;
            if (bus.i_halt_id) begin
               state_d    = ST_DRAIN;
               drain_load = 1'b1;
            end else begin
               if (stall) begin
                  idex_bubble = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
                  ifid_flush = bus.i_flush_req;
               end
               if (state_q == ST_STEP)
                  state_d = ST_IDLE;
            end
         end
         (state_q == ST_DRAIN): begin
            pipe_en     = 1'b1;
            idex_bubble = 1'b1;
            if (drain_q <= DW'(1))
               state_d = ST_HALTED;
         end
         (state_q == ST_HALTED): begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset always lands in IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Drain countdown, loaded as HALT leaves ID.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         drain_q <= '0;
      else if (drain_load)
         drain_q <= DW'(DRAIN_CYCLES);
      else if (state_q == ST_DRAIN && drain_q != '0)
         drain_q <= drain_q - DW'(1);
   end

   assign bus.o_pipe_en     = pipe_en;
   assign bus.o_pc_write    = pc_write;
   assign bus.o_ifid_write  = ifid_write;
   assign bus.o_ifid_flush  = ifid_flush;
   assign bus.o_idex_bubble = idex_bubble;
   assign bus.o_halted      = halted;

`ifdef PIPE_CYCLE_COUNT_EN
   logic [CNTBITS-1:0] cyc_q;

   // Count every edge the pipeline advances; wraps naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cyc_q <= '0;
      else if (pipe_en)
         cyc_q <= cyc_q + CNTBITS'(1);
   end

   assign bus.o_cycle_count = cyc_q;
`else
   assign bus.o_cycle_count = {CNTBITS{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_run_controller.sv
// Self-checking bench for pipe_run_controller.
// Directed scenarios plus randomized run against a flag-based model.
module tb_pipe_run_controller;

   localparam int DRAIN = 3;
`ifdef PIPE_CYCLE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_run_controller_if #(.RBITS(5), .CNTBITS(32)) bus ();

   pipe_run_controller #(
      .DRAIN_CYCLES (DRAIN),
      .RBITS        (5),
      .CNTBITS      (32)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int errors = 0;
   int checks = 0;

   // model: running, single step armed, drain cycles left, finished
   bit          m_run;
   bit          m_step;
   bit          m_done;
   int          m_left;
   logic [31:0] m_cnt;

   logic [5:0]  exp_o;
   logic [31:0] exp_cnt;
   wire  [5:0]  act_o = {bus.o_pipe_en, bus.o_pc_write, bus.o_ifid_write,
                         bus.o_ifid_flush, bus.o_idex_bubble, bus.o_halted};

   task automatic set_in(input bit st, input bit sp, input bit hl,
                         input bit fl, input bit mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt);
      bus.i_start         = st;
      bus.i_step          = sp;
      bus.i_halt_id       = hl;
      bus.i_flush_req     = fl;
      bus.i_idex_mem_read = mr;
      bus.i_idex_rt       = xrt;
      bus.i_ifid_rs       = rs;
      bus.i_ifid_rt       = rt;
   endtask

   task automatic predict;
      bit active, drain, stall, halt, go;
      active = m_run | m_step;
      drain  = (m_left > 0);
      stall  = active && bus.i_idex_mem_read && (bus.i_idex_rt != 0) &&
               ((bus.i_idex_rt == bus.i_ifid_rs) ||
                (bus.i_idex_rt == bus.i_ifid_rt));
      halt   = active && bus.i_halt_id;
      go     = active && !halt && !stall;
      exp_o  = {active || drain, go, go, go && bus.i_flush_req,
                (active && !halt && stall) || drain, m_done};
      exp_cnt = CNT_EN ? m_cnt : 32'd0;
   endtask

   task automatic apply(input bit st, input bit sp, input bit hl,
                        input bit fl, input bit mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt);
      set_in(st, sp, hl, fl, mr, xrt, rs, rt);
      #1;
      predict();
   endtask

   task automatic tick;
      bit active;
      @(posedge clk);
      active = m_run | m_step;
      if (active || m_left > 0)
         m_cnt = m_cnt + 32'd1;
      if (m_done) begin
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0)
            m_done = 1'b1;
      end else if (active) begin
         if (bus.i_halt_id) begin
            m_run  = 1'b0;
            m_step = 1'b0;
            m_left = DRAIN;
         end else if (m_step) begin
            m_step = 1'b0;
         end
      end else if (bus.i_start) begin
         m_run = 1'b1;
      end else if (bus.i_step) begin
         m_step = 1'b1;
      end
      #1;
   endtask

   task automatic model_clear;
      m_run  = 1'b0;
      m_step = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_cnt  = 32'd0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      set_in(1, 1, 1, 1, 1, 5'd3, 5'd3, 5'd3);
      repeat (2) @(posedge clk);
      #2;
      if (act_o !== 6'b000000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=000000", act_o);
      end
      checks++;
      if (bus.o_cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_count got=%0d exp=0", bus.o_cycle_count);
      end
      checks++;
   endtask

   task automatic test_run;
      do_reset();
      for (int c = 1; c <= 8; c++) begin
         apply(c == 2, 0, 0, 0, 0, 0, 0, 0);
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL run_c%0d got=%b exp=%b", c, act_o, exp_o);
         end
         checks++;
         if (bus.o_pipe_en !== (c >= 3)) begin
            errors++;
            $display("FAIL run_en_c%0d got=%b exp=%b", c, bus.o_pipe_en, c >= 3);
         end
         checks++;
         if (c == 8 && bus.o_cycle_count !== (CNT_EN ? 32'd5 : 32'd0)) begin
            errors++;
            $display("FAIL run_count got=%0d exp=%0d",
                     bus.o_cycle_count, CNT_EN ? 5 : 0);
         end
         if (c == 8)
            checks++;
         tick();
      end
   endtask

   task automatic test_step;
      int en_seen;
      en_seen = 0;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         apply((c % 4) == 0 && c < 12 ? 1'b0 : 1'b0, (c % 4) == 0 && c < 12,
               0, 0, 0, 0, 0, 0);
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL step_c%0d got=%b exp=%b", c, act_o, exp_o);
         end
         checks++;
         en_seen += int'(bus.o_pipe_en);
         tick();
      end
      if (en_seen != 3) begin
         errors++;
         $display("FAIL step_en_cycles got=%0d exp=3", en_seen);
      end
      checks++;
      if (bus.o_cycle_count !== (CNT_EN ? 32'd3 : 32'd0)) begin
         errors++;
         $display("FAIL step_count got=%0d exp=%0d",
                  bus.o_cycle_count, CNT_EN ? 3 : 0);
      end
      checks++;
   endtask

   task automatic test_hazard;
      logic [5:0] want [4];
      want[0] = 6'b100010;
      want[1] = 6'b111100;
      want[2] = 6'b100010;
      want[3] = 6'b111100;
      do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         unique case (k)
            0: apply(0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd3);
            1: apply(0, 0, 0, 1, 1, 5'd0, 5'd8, 5'd0);
            2: apply(0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9);
            default: apply(0, 0, 0, 1, 0, 5'd9, 5'd9, 5'd9);
         endcase
         if (act_o !== want[k]) begin
            errors++;
            $display("FAIL hazard_%0d got=%b exp=%b", k, act_o, want[k]);
         end
         checks++;
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL hazard_model_%0d got=%b exp=%b", k, act_o, exp_o);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_halt;
      logic [5:0] want;
      do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      for (int c = 0; c < 10; c++) begin
         apply(c >= 7, c == 8, c == 2, 1, 0, 0, 0, 0);
         if (c < 2)
            want = 6'b111100;
         else if (c == 2)
            want = 6'b100000;
         else if (c < 6)
            want = 6'b100010;
         else
            want = 6'b000001;
         if (act_o !== want) begin
            errors++;
            $display("FAIL halt_c%0d got=%b exp=%b", c, act_o, want);
         end
         checks++;
         if (bus.o_cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL halt_count_c%0d got=%0d exp=%0d",
                     c, bus.o_cycle_count, exp_cnt);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 1, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      if (act_o !== 6'b100010) begin
         errors++;
         $display("FAIL areset_pre got=%b exp=100010", act_o);
      end
      checks++;
      rst_n = 1'b0;
      #1;
      if (act_o !== 6'b000000) begin
         errors++;
         $display("FAIL areset_outputs got=%b exp=000000", act_o);
      end
      checks++;
      if (bus.o_cycle_count !== 32'd0) begin
         errors++;
         $display("FAIL areset_count got=%0d exp=0", bus.o_cycle_count);
      end
      checks++;
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      if (act_o !== exp_o || exp_o !== 6'b111000) begin
         errors++;
         $display("FAIL areset_restep got=%b exp=111000", act_o);
      end
      checks++;
      tick();
   endtask

   task automatic test_random;
      int done_cycles;
      done_cycles = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (m_done) begin
            done_cycles++;
            if (done_cycles > 3) begin
               do_reset();
               done_cycles = 0;
            end
         end
         apply($urandom_range(7) == 0, $urandom_range(5) == 0,
               $urandom_range(30) == 0, $urandom_range(2) == 0,
               $urandom_range(1) == 1, 5'($urandom_range(3)),
               5'($urandom_range(3)), 5'($urandom_range(3)));
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL rand_c%0d got=%b exp=%b", c, act_o, exp_o);
         end
         checks++;
         if (bus.o_cycle_count !== exp_cnt) begin
            errors++;
            $display("FAIL rand_count_c%0d got=%0d exp=%0d",
                     c, bus.o_cycle_count, exp_cnt);
         end
         checks++;
         tick();
      end
   endtask

   initial begin
      model_clear();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_run();
      test_step();
      test_hazard();
      test_halt();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_run_controller.md
PIPE_RUN_CONTROLLER -- requirements
Module: pipe_run_controller

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles allowed after HALT leaves ID for EX/MEM/WB to retire.
REQ-002 Parameter RBITS, default 5: register specifier width.
REQ-003 Parameter CNTBITS, default 32: cycle counter width.
REQ-004 i_clk  input  1  single system clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  one-cycle pulse: enter continuous run.
REQ-007 i_step  input  1  one-cycle pulse: advance pipeline exactly one cycle.
REQ-008 i_halt_id  input  1  HALT instruction currently decoded in ID.
REQ-009 i_flush_req  input  1  taken branch/jump resolved in ID.
REQ-010 i_idex_mem_read  input  1  Mem_read of instruction in EX.
REQ-011 i_idex_rt  input  RBITS  destination rt of instruction in EX.
REQ-012 i_ifid_rs, i_ifid_rt  input  RBITS each  source specifiers of instruction in ID.
REQ-013 o_pipe_en  output  1  global pipeline-register enable.
REQ-014 o_pc_write  output  1  PC update enable.
REQ-015 o_ifid_write  output  1  IF/ID register write enable.
REQ-016 o_ifid_flush  output  1  clear IF/ID to NOP.
REQ-017 o_idex_bubble  output  1  load zeroed control into ID/EX.
REQ-018 o_halted  output  1  program finished, pipeline drained.
REQ-019 o_cycle_count  output  CNTBITS  count of enabled pipeline cycles.

Function
REQ-020 State register SHALL take one of IDLE, RUN, STEP, DRAIN, HALTED; outputs SHALL be combinational from state and inputs.
REQ-021 IDLE: o_pipe_en=0, o_pc_write=0, o_ifid_write=0; i_start -> RUN; else i_step -> STEP; both asserted -> RUN.
REQ-022 Start/step pulse sampled at edge N SHALL give o_pipe_en=1 during cycle N+1.
REQ-023 STEP: o_pipe_en=1 for exactly one cycle, then IDLE, unless i_halt_id asserted that cycle (-> DRAIN).
REQ-024 RUN: o_pipe_en=1; remains until i_halt_id, then -> DRAIN.
REQ-025 In the cycle i_halt_id is seen in RUN/STEP: o_pc_write=0, o_ifid_write=0, o_idex_bubble=0 (HALT propagates once); drain counter loaded with DRAIN_CYCLES.
REQ-026 DRAIN: o_pipe_en=1, o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; counter decrements each cycle; at counter=1 -> HALTED next edge.
REQ-027 HALTED: o_pipe_en=0, o_halted=1; i_start/i_step ignored; exit only via reset.
REQ-028 Load-use stall, active in RUN/STEP: i_idex_mem_read=1, i_idex_rt!=0, and i_idex_rt equals i_ifid_rs or i_ifid_rt -> o_pc_write=0, o_ifid_write=0, o_idex_bubble=1 for that cycle.
REQ-029 i_flush_req in RUN/STEP without stall -> o_ifid_flush=1, o_pc_write=1.
REQ-030 Priority SHALL be: halt > stall > flush; stall suppresses o_ifid_flush (branch re-evaluated next cycle).
REQ-031 Outside RUN/STEP, o_ifid_flush=0 and stall/flush inputs SHALL be ignored.
REQ-032 o_cycle_count SHALL increment on each edge with o_pipe_en=1, wrapping from all-ones to 0.

Reset
REQ-033 i_rst_n low SHALL immediately force IDLE, drain counter 0, o_cycle_count 0, o_halted 0, all enables 0, regardless of state, including mid-DRAIN.
REQ-034 First state change after reset release SHALL occur on the first rising edge with i_rst_n high.

Configuration
REQ-035 Macro PIPE_CYCLE_COUNT_EN defined: counter implemented per REQ-032; undefined: no counter flops, o_cycle_count tied to 0.

Structure
REQ-036 Shared package SHALL hold state encoding, DRAIN_CYCLES default and HALT opcode constant.
REQ-037 Load-use comparison SHALL be a combinational sub-module hazard_detect, instantiated once.

Verification
REQ-038 Reset, i_start at cycle 2 -> o_pipe_en=1 from cycle 3, o_cycle_count=5 after 5 RUN cycles.
REQ-039 IDLE, three i_step pulses 4 cycles apart -> exactly three single o_pipe_en cycles, o_cycle_count=3.
REQ-040 RUN, mem_read=1, idex_rt=8, ifid_rs=8, flush_req=1 -> pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; same with idex_rt=0 -> no stall, ifid_flush=1.
REQ-041 RUN, i_halt_id one cycle -> 1 HALT cycle + 3 DRAIN cycles with pc_write=0, then o_halted=1, o_pipe_en=0; later i_start has no effect.
REQ-042 i_rst_n low during second DRAIN cycle -> IDLE, o_halted=0, o_cycle_count=0 asynchronously.
